// File: rtl/fc_mac_engine.sv
// fc_mac_engine: captures a 9-byte activation window and computes NUM_OUT
// fully-connected dot products with one serial MAC. Weights come from an
// external sync ROM with 1-cycle read latency. Results leave on a
// valid/ready stream, one result per neuron.
module fc_mac_engine #(
  parameter int NUM_OUT = 10,
  parameter int ACC_W   = 24,
  parameter int W_AW    = 7,
  parameter int IDX_W   = 4,
  parameter int RELU    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fc_ready,
  input  logic [71:0]             fc_data,
  output logic                    w_rd_en,
  output logic [W_AW-1:0]         w_addr,
  input  logic signed [7:0]       w_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [ACC_W-1:0] o_data,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_last,
  output logic                    busy,
  output logic                    err_overrun
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  localparam logic [IDX_W-1:0] LAST_N = IDX_W'(NUM_OUT - 1);

  state_t                  state;
  logic [3:0]              k;
  logic [IDX_W-1:0]        neuron;
  logic signed [ACC_W-1:0] acc;
  logic [71:0]             window;

  logic                    hs;
  logic                    last_n;
  logic                    accept;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;

  // Element idx of the window; element 0 sits in the top byte.
  function automatic logic [7:0] act_at(input logic [71:0] win, input logic [3:0] idx);
    logic [71:0] s;
    s = win << (8 * idx);
    return s[71:64];
  endfunction

  // Unsigned activation times signed weight, 17-bit product sign-extended.
  function automatic logic signed [ACC_W-1:0] mac_prod(input logic [7:0] a,
                                                       input logic signed [7:0] w);
    logic signed [16:0] p;
    p = $signed({1'b0, a}) * w;
    return {{(ACC_W-17){p[16]}}, p};
  endfunction

  // Optional clamp of negative results, applied only on the way out.
  function automatic logic signed [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] x);
    if ((RELU != 0) && x[ACC_W-1]) return '0;
    return x;
  endfunction

  assign w_rd_en = (state == RUN) && (k <= 4'd8);
  assign w_addr  = w_rd_en ? (W_AW'(neuron) * W_AW'(9) + W_AW'(k)) : '0;

  // Weight read at step k arrives at step k+1, so it pairs with element k-1.
  assign prod   = mac_prod(act_at(window, k - 4'd1), w_data);
  assign sum    = acc + prod;
  assign hs     = o_valid && o_ready;
  assign last_n = (neuron == LAST_N);
  // A window is only taken when idle or on the final handshake of a job.
  assign accept = fc_ready && ((state == IDLE) || ((state == OUT) && hs && last_n));

  // Control FSM, MAC accumulator and registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      neuron      <= '0;
      acc         <= '0;
      window      <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_idx       <= '0;
      o_last      <= 1'b0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= fc_ready && !accept;
      case (state)
        IDLE: begin
          if (fc_ready) begin
            window <= fc_data;
            neuron <= '0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (k == 4'd0) acc <= '0;
          else           acc <= sum;
          if (k == 4'd9) begin
            o_data  <= relu_clamp(sum);
            o_idx   <= neuron;
            o_last  <= last_n;
            o_valid <= 1'b1;
            state   <= OUT;
          end else begin
            k <= k + 4'd1;
          end
        end
        OUT: begin
          if (hs) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (!last_n) begin
              neuron <= neuron + IDX_W'(1);
              k      <= '0;
              state  <= RUN;
            end else if (fc_ready) begin
              window <= fc_data;
              neuron <= '0;
              k      <= '0;
              state  <= RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// Testbench for fc_mac_engine: weight ROM model, scoreboard of expected
// results, table-driven windows and hand-written corner-case sequences.
// A second instance built with RELU=1 runs in lockstep on the same stimulus.
module tb_fc_mac_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fc_ready, o_ready;
  logic [71:0] fc_data;

  logic              w_rd_en, o_valid, o_last, busy, err_overrun;
  logic [6:0]        w_addr;
  logic signed [7:0] w_data;
  logic [23:0]       o_data;
  logic [3:0]        o_idx;

  logic              w_rd_en_r, o_valid_r, o_last_r, busy_r, err_overrun_r;
  logic [6:0]        w_addr_r;
  logic signed [7:0] w_data_r;
  logic [23:0]       o_data_r;
  logic [3:0]        o_idx_r;

  fc_mac_engine dut (
    .clk(clk), .rst(rst), .fc_ready(fc_ready), .fc_data(fc_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx),
    .o_last(o_last), .busy(busy), .err_overrun(err_overrun)
  );

  fc_mac_engine #(.RELU(1)) dut_r (
    .clk(clk), .rst(rst), .fc_ready(fc_ready), .fc_data(fc_data),
    .w_rd_en(w_rd_en_r), .w_addr(w_addr_r), .w_data(w_data_r),
    .o_valid(o_valid_r), .o_ready(o_ready), .o_data(o_data_r), .o_idx(o_idx_r),
    .o_last(o_last_r), .busy(busy_r), .err_overrun(err_overrun_r)
  );

  logic signed [7:0] rom [0:127];

  // Synchronous weight ROM, one-cycle read latency, one port per instance.
  always @(posedge clk) begin
    if (w_rd_en)   w_data   <= rom[w_addr];
    if (w_rd_en_r) w_data_r <= rom[w_addr_r];
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] d;
    logic [3:0]  idx;
    logic        last;
  } exp_t;
  exp_t q[$];
  exp_t qr[$];

  typedef struct {
    logic [71:0]       win;
    logic signed [7:0] wfill;
    logic [23:0]       exp;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] relu_ref(input logic [23:0] d);
    return d[23] ? 24'd0 : d;
  endfunction

  function automatic logic [23:0] model(input logic [71:0] win, input int n);
    logic signed [31:0] s;
    logic [7:0]         a;
    s = 0;
    for (int j = 0; j < 9; j++) begin
      a = win[71-8*j -: 8];
      s += $signed({1'b0, a}) * rom[n*9+j];
    end
    return s[23:0];
  endfunction

  task automatic push(input logic [23:0] d, input int n);
    exp_t e;
    e.d = d; e.idx = 4'(n); e.last = (n == 9);
    q.push_back(e);
    e.d = relu_ref(d);
    qr.push_back(e);
  endtask

  task automatic push_model(input logic [71:0] win);
    for (int n = 0; n < 10; n++) push(model(win, n), n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window is presented for one cycle only; fc_data is scrambled afterwards.
  task automatic start_job(input logic [71:0] win);
    fc_ready = 1'b1;
    fc_data  = win;
    tick();
    fc_ready = 1'b0;
    fc_data  = {$urandom, $urandom, 8'($urandom)};
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    if (cnt >= 100) chk("wait_valid_timeout", 64'(cnt), 64'd0);
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 3000) begin
      if (rnd) o_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    o_ready = 1'b1;
    if (n >= 3000) chk("wait_idle_timeout", 64'(n), 64'd0);
  endtask

  logic        hold;
  logic [23:0] hd;
  logic [3:0]  hi;

  // Scoreboard pop on each handshake, plus stability check under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_data", 64'(o_data), 64'(hd));
        chk("hold_idx", 64'(o_idx), 64'(hi));
      end
      hold = o_valid && !o_ready;
      hd   = o_data;
      hi   = o_idx;
      if (o_valid && o_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got idx %0d data %0h, expected none", o_idx, o_data);
        end else begin
          e = q.pop_front();
          chk("o_data", 64'(o_data), 64'(e.d));
          chk("o_idx", 64'(o_idx), 64'(e.idx));
          chk("o_last", 64'(o_last), 64'(e.last));
        end
      end
      if (o_valid_r && o_ready) begin
        if (qr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output_relu: got idx %0d data %0h, expected none", o_idx_r, o_data_r);
        end else begin
          e = qr.pop_front();
          chk("relu_o_data", 64'(o_data_r), 64'(e.d));
          chk("relu_o_idx", 64'(o_idx_r), 64'(e.idx));
        end
      end
    end
  end

  initial begin
    int          c;
    logic [71:0] win;

    rst = 1'b1; fc_ready = 1'b0; fc_data = '0; o_ready = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 8'sd0;
    repeat (3) tick();

    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_w_rd_en", 64'(w_rd_en), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    chk("rst_o_data", 64'(o_data), 64'd0);
    chk("rst_o_idx", 64'(o_idx), 64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    rst = 1'b0;
    tick();

    vecs[0] = '{{9{8'd1}},   8'sd1,    24'd9};
    vecs[1] = '{{9{8'hFF}},  -8'sd128, 24'hFB8480};
    vecs[2] = '{72'd0,       8'sd77,   24'd0};
    vecs[3] = '{{9{8'hFF}},  8'sd127,  24'd291465};
    vecs[4] = '{{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, -8'sd1, 24'hFFFFD3};

    // Constant-weight table: every neuron yields the same value.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 128; j++) rom[j] = vecs[i].wfill;
      for (int n = 0; n < 10; n++) push(vecs[i].exp, n);
      start_job(vecs[i].win);
      chk("busy_after_capture", 64'(busy), 64'd1);
      wait_valid(c);
      chk("first_latency", 64'(c), 64'd10);
      wait_idle(1'b0);
    end

    // Element and weight ordering.
    for (int j = 0; j < 128; j++) rom[j] = 8'sd0;
    rom[4]  = 8'sd1;
    rom[17] = -8'sd2;
    push(24'd5, 0);
    push(24'hFFFFEE, 1);
    for (int n = 2; n < 10; n++) push(24'd0, n);
    start_job({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    wait_idle(1'b0);
    chk("idle_after_job", 64'(busy), 64'd0);

    // Random windows and weights under random backpressure.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 128; j++) rom[j] = 8'($urandom);
      win = {$urandom, $urandom, 8'($urandom)};
      push_model(win);
      start_job(win);
      wait_idle(1'b1);
    end

    // Backpressure held for 5 cycles on neuron 3.
    win = {$urandom, $urandom, 8'($urandom)};
    push_model(win);
    o_ready = 1'b0;
    start_job(win);
    for (int n = 0; n < 10; n++) begin
      wait_valid(c);
      chk("bp_seq_idx", 64'(o_idx), 64'(n));
      if (n == 3) begin
        repeat (5) begin
          tick();
          chk("bp_valid_held", 64'(o_valid), 64'd1);
          chk("bp_idx_held", 64'(o_idx), 64'd3);
        end
      end
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      if (n == 3) chk("bp_release_valid", 64'(o_valid), 64'd0);
    end
    o_ready = 1'b1;
    wait_idle(1'b0);

    // Overrun during RUN, then a new window on the final handshake.
    win = {$urandom, $urandom, 8'($urandom)};
    push_model(win);
    start_job(win);
    repeat (3) tick();
    fc_ready = 1'b1;
    fc_data  = {$urandom, $urandom, 8'($urandom)};
    tick();
    fc_ready = 1'b0;
    chk("overrun_pulse", 64'(err_overrun), 64'd1);
    tick();
    chk("overrun_clear", 64'(err_overrun), 64'd0);
    c = 0;
    while (!(o_valid && o_idx == 4'd9) && c < 200) begin
      tick();
      c++;
    end
    if (c >= 200) chk("final_wait_timeout", 64'(c), 64'd0);
    win = {$urandom, $urandom, 8'($urandom)};
    push_model(win);
    fc_ready = 1'b1;
    fc_data  = win;
    tick();
    fc_ready = 1'b0;
    chk("chain_no_err", 64'(err_overrun), 64'd0);
    chk("chain_busy", 64'(busy), 64'd1);
    wait_valid(c);
    chk("chain_latency", 64'(c), 64'd10);
    wait_idle(1'b0);

    // Reset in the middle of neuron 2.
    win = {$urandom, $urandom, 8'($urandom)};
    push_model(win);
    start_job(win);
    c = 0;
    while (!(o_valid && o_idx == 4'd1) && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) chk("mid_wait_timeout", 64'(c), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    qr.delete();
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_w_rd_en", 64'(w_rd_en), 64'd0);
    repeat (15) tick();
    chk("midrst_no_output", 64'(o_valid), 64'd0);
    win = {$urandom, $urandom, 8'($urandom)};
    push_model(win);
    start_job(win);
    wait_valid(c);
    chk("restart_idx", 64'(o_idx), 64'd0);
    wait_idle(1'b0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
